// File: rtl/multi_delay_timer_pkg.sv
// Shared definitions for the multi-channel delay timer: channel FSM state
// encoding and the per-channel mode values.
package multi_delay_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/delay_timer_channel.sv
// One timer channel: latches its delay on start, counts prescaler ticks and
// pulses Timeout on each expiry (periodic) or once before parking in DONE.
module delay_timer_channel
  import multi_delay_timer_pkg::*;
#(
  parameter int NumberOfBits = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Tick,
  input  logic                    Start,
  input  logic                    Mode,
  input  logic [NumberOfBits-1:0] Speed,
  output logic                    Timeout,
  output logic                    Done,
  output logic                    Busy,
  output state_t                  State
);

  localparam logic [NumberOfBits-1:0] ONE = {{(NumberOfBits-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [NumberOfBits-1:0] count;
  logic [NumberOfBits-1:0] speed_l;

  assign State = state;

  // Dropping Start outranks an expiry landing in the same cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      speed_l <= '0;
      Timeout <= 1'b0;
      Done    <= 1'b0;
      Busy    <= 1'b0;
    end else if (!Start) begin
      state   <= ST_IDLE;
      count   <= '0;
      Timeout <= 1'b0;
      Done    <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      Timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Speed != '0) begin
            speed_l <= Speed;
            count   <= '0;
            state   <= ST_COUNT;
            Busy    <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (Tick) begin
            // Expiry compare is the only wrap point, so all-ones never overflows.
            if (count == speed_l - ONE) begin
              Timeout <= 1'b1;
              count   <= '0;
              if (Mode == MODE_ONESHOT) begin
                state <= ST_DONE;
                Busy  <= 1'b0;
                Done  <= 1'b1;
              end
            end else begin
              count <= count + ONE;
            end
          end
        end
        ST_DONE: begin
          Done <= 1'b1;
          Busy <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_delay_timer.sv
// Multi-channel programmable delay/period timer: a shared prescaler ticks
// Channels independent delay_timer_channel instances.
module multi_delay_timer
  import multi_delay_timer_pkg::*;
#(
  parameter int NumberOfBits = 8,
  parameter int Channels     = 4,
  parameter int PrescaleBits = 4
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [Channels-1:0]              Start,
  input  logic [Channels-1:0]              Mode,
  input  logic [Channels*NumberOfBits-1:0] Speed,
  input  logic [PrescaleBits-1:0]          Prescale,
  output logic [Channels-1:0]              Timeout,
  output logic [Channels-1:0]              Done,
  output logic [Channels-1:0]              Busy,
  output logic [2*Channels-1:0]            State
);

  localparam logic [PrescaleBits-1:0] PC_ONE = {{(PrescaleBits-1){1'b0}}, 1'b1};

  logic [PrescaleBits-1:0] pc;
  logic                    tick;
  logic                    any_busy;

  // The >= lets a lowered Prescale take effect without waiting for a wrap.
  assign tick     = (pc >= Prescale);
  assign any_busy = |Busy;

  always_ff @(posedge Clock) begin
    if (Reset || !any_busy) begin
      pc <= '0;
    end else if (tick) begin
      pc <= '0;
    end else begin
      pc <= pc + PC_ONE;
    end
  end

  for (genvar i = 0; i < Channels; i++) begin : g_ch
    delay_timer_channel #(
      .NumberOfBits(NumberOfBits)
    ) u_ch (
      .Clock  (Clock),
      .Reset  (Reset),
      .Tick   (tick),
      .Start  (Start[i]),
      .Mode   (Mode[i]),
      .Speed  (Speed[i*NumberOfBits +: NumberOfBits]),
      .Timeout(Timeout[i]),
      .Done   (Done[i]),
      .Busy   (Busy[i]),
      .State  (State[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Randomised and directed bench for multi_delay_timer against a tick-counting
// reference model, with directed period/latency checks.
module tb_multi_delay_timer;
  import multi_delay_timer_pkg::*;

  localparam int NB = 8;
  localparam int CH = 4;
  localparam int PB = 4;
  localparam int W  = 5*CH + PB;

  // clock / reset
  logic              Clock = 1'b0;
  logic              Reset;
  logic [CH-1:0]     Start, Mode;
  logic [CH*NB-1:0]  Speed;
  logic [PB-1:0]     Prescale;
  logic [CH-1:0]     Timeout, Done, Busy;
  logic [2*CH-1:0]   State;

  always #5 Clock = ~Clock;

  multi_delay_timer #(.NumberOfBits(NB), .Channels(CH), .PrescaleBits(PB)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode), .Speed(Speed),
    .Prescale(Prescale), .Timeout(Timeout), .Done(Done), .Busy(Busy), .State(State)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ei = 0;

  // reference model: ticks counted since the channel was started
  bit            m_run [CH];
  bit            m_done[CH];
  int            m_lat [CH];
  int            m_ticks[CH];
  logic [CH-1:0] m_to = '0, m_dn = '0, m_bs = '0;
  logic [2*CH-1:0] m_st = '0;
  int            m_pc = 0;

  logic [W-1:0]  exp_q[$];

  int pulses[CH], first_to[CH], last_to[CH], period[CH];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ei);
    end
  endtask

  task automatic clear_track();
    ei = 0;
    for (int c = 0; c < CH; c++) begin
      pulses[c] = 0; first_to[c] = -1; last_to[c] = -1; period[c] = 0;
    end
  endtask

  task automatic model_step();
    bit            tk;
    bit            any;
    logic [NB-1:0] sp;
    tk  = (m_pc >= int'(Prescale));
    any = |m_bs;
    for (int c = 0; c < CH; c++) begin
      sp = Speed[c*NB +: NB];
      m_to[c] = 1'b0;
      if (Reset || !Start[c]) begin
        m_run[c] = 0; m_done[c] = 0; m_ticks[c] = 0;
      end else if (m_done[c]) begin
        m_run[c] = 0;
      end else if (!m_run[c]) begin
        if (sp != 0) begin
          m_run[c] = 1; m_lat[c] = int'(sp); m_ticks[c] = 0;
        end
      end else if (tk) begin
        m_ticks[c]++;
        if (m_ticks[c] == m_lat[c]) begin
          m_to[c] = 1'b1;
          m_ticks[c] = 0;
          if (Mode[c] == MODE_ONESHOT) begin
            m_run[c] = 0; m_done[c] = 1;
          end
        end
      end
      m_dn[c] = m_done[c];
      m_bs[c] = m_run[c];
      m_st[2*c +: 2] = m_done[c] ? 2'(ST_DONE) : (m_run[c] ? 2'(ST_COUNT) : 2'(ST_IDLE));
    end
    if (Reset || !any || tk) m_pc = 0;
    else m_pc = m_pc + 1;
    exp_q.push_back({m_to, m_dn, m_bs, m_st, PB'(m_pc)});
  endtask

  task automatic sample();
    logic [W-1:0] e;
    check_eq("sb_depth", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check_eq("timeout", Timeout, e[W-1 -: CH]);
    check_eq("done",    Done,    e[W-1-CH -: CH]);
    check_eq("busy",    Busy,    e[W-1-2*CH -: CH]);
    check_eq("state",   State,   e[PB +: 2*CH]);
    check_eq("pc",      dut.pc,  e[PB-1:0]);
    for (int c = 0; c < CH; c++) begin
      if (Timeout[c]) begin
        if (last_to[c] >= 0) period[c] = ei - last_to[c];
        if (first_to[c] < 0) first_to[c] = ei;
        last_to[c] = ei;
        pulses[c]++;
      end
    end
  endtask

  // driver: one clock per iteration, inputs change 1ns after the edge
  task automatic step(int n);
    repeat (n) begin
      @(posedge Clock);
      model_step();
      #1;
      sample();
      ei++;
    end
  endtask

  initial begin
    int idx;
    clear_track();
    Reset = 1'b1; Start = '1; Mode = 4'b0100; Prescale = '0;
    Speed = {8'd7, 8'd3, 8'd0, 8'd5};
    step(3);

    // periodic ch0, disabled ch1, one-shot ch2
    Reset = 1'b0; clear_track(); step(16);
    check_eq("ch0_pulses", pulses[0], 3);
    check_eq("ch0_first", first_to[0], 5);
    check_eq("ch0_last", last_to[0], 15);
    check_eq("ch0_period", period[0], 5);
    check_eq("ch1_pulses", pulses[1], 0);
    check_eq("ch2_pulses", pulses[2], 1);
    check_eq("ch2_first", first_to[2], 3);
    check_eq("ch2_done_held", Done[2], 1);
    Start[2] = 1'b0; step(1);
    check_eq("ch2_done_clr", Done[2], 0);
    Start[2] = 1'b1; clear_track(); step(5);
    check_eq("ch2_restart", first_to[2], 3);

    // prescaled period, Speed change ignored mid-count, relatch on restart
    Start = '0; Mode = '0; Prescale = 4'd2; step(2);
    Speed = {24'd0, 8'd4}; Start = 4'b0001; clear_track(); step(14);
    Speed = {24'd0, 8'd9}; step(26);
    check_eq("pre_period", period[0], 12);
    check_eq("pre_pulses", pulses[0], 3);
    Start = '0; step(1);
    Start = 4'b0001; clear_track(); step(60);
    check_eq("relatch_first", first_to[0], 27);
    check_eq("relatch_period", period[0], 27);

    // Start dropped on the expiring cycle; reset mid-count
    Prescale = '0; Start = '0; step(1);
    Speed = {24'd0, 8'd4}; Start = 4'b0001; clear_track(); step(4);
    Start = '0; step(2);
    check_eq("drop_no_to", pulses[0], 0);
    Speed = {8'd9, 8'd6, 8'd5, 8'd7}; Start = '1; step(5);
    Reset = 1'b1; step(1);
    check_eq("rst_busy", Busy, 0);
    Reset = 1'b0; Start = '0; step(1);

    // simultaneous expiries, then all-ones delay
    Speed = {8'd2, 8'd2, 8'd2, 8'd2}; Start = '1; clear_track(); step(9);
    for (int c = 0; c < CH; c++) begin
      check_eq($sformatf("sim_pulses%0d", c), pulses[c], 4);
      check_eq($sformatf("sim_last%0d", c), last_to[c], 8);
    end
    Start = '0; step(1);
    Speed = {8'hFF, 24'd0}; Start = 4'b1000; clear_track(); step(257);
    check_eq("ff_first", first_to[3], 255);
    check_eq("ff_pulses", pulses[3], 1);

    // randomised traffic against the model
    Start = '0; step(1);
    for (int k = 0; k < 400; k++) begin
      idx = $urandom_range(0, CH-1);
      if ($urandom_range(0, 7) == 0) Start[idx] = ~Start[idx];
      if ($urandom_range(0, 19) == 0) Mode = CH'($urandom);
      if ($urandom_range(0, 9) == 0) Speed[idx*NB +: NB] = NB'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) Prescale = PB'($urandom_range(0, 3));
      Reset = ($urandom_range(0, 99) == 0);
      step(1);
    end
    Reset = 1'b0; step(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
